// File: rtl/pipeline_pkg.sv
// Shared front-end pipeline definitions: NOP encoding, PC step and next-PC select codes
// used by the fetch controller and the hazard/branch units.
package pipeline_pkg;

  localparam int          XLEN_DEFAULT = 32;
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;
  localparam int          PC_STEP      = 4;

  typedef enum logic [1:0] {
    ADV   = 2'd0,
    HOLD  = 2'd1,
    REDIR = 2'd2
  } next_pc_sel_e;

endpackage

// File: rtl/pc_stall_ctrl_stall_watchdog.sv
// Counts consecutive stalled cycles and forces a release once MAX_STALL is reached;
// the error flag stays set until reset.
module stall_watchdog #(
  parameter int MAX_STALL = 3
) (
  input  logic CLK,
  input  logic Reset,
  input  logic stall_req,
  input  logic flush_req,
  output logic force_release,
  output logic stall_err
);

  localparam int CW = $clog2(MAX_STALL + 2);

  logic [CW-1:0] stall_cnt_q, stall_cnt_d;
  logic          stall_err_q, stall_err_d;

  assign force_release = stall_req && !flush_req && (stall_cnt_q == CW'(MAX_STALL));
  assign stall_err     = stall_err_q;

  always_comb begin
    stall_cnt_d = '0;
    stall_err_d = stall_err_q;
    if (force_release) begin
      stall_err_d = 1'b1;
    end else if (stall_req && !flush_req) begin
      stall_cnt_d = stall_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      stall_cnt_q <= '0;
      stall_err_q <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      stall_err_q <= stall_err_d;
    end
  end

endmodule

// File: rtl/pc_stall_ctrl.sv
// PC register plus IF/ID pipeline register, steered by flush/stall requests from the
// hazard side, with a stall watchdog and a bubble performance counter.
module pc_stall_ctrl
  import pipeline_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              MAX_STALL = 3,
  parameter int              CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             stall_req,
  input  logic             flush_req,
  input  logic [XLEN-1:0]  flush_target,
  input  logic [XLEN-1:0]  imem_rdata,
  output logic [XLEN-1:0]  imem_addr,
  output logic [XLEN-1:0]  if_pc,
  output logic [XLEN-1:0]  if_inst,
  output logic             if_valid,
  output logic             stall_err,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  if_pc_q, if_pc_d;
  logic [XLEN-1:0]  if_inst_q, if_inst_d;
  logic             if_valid_q, if_valid_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;
  logic             force_release;
  next_pc_sel_e     sel;

  stall_watchdog #(
    .MAX_STALL (MAX_STALL)
  ) u_watchdog (
    .CLK           (CLK),
    .Reset         (Reset),
    .stall_req     (stall_req),
    .flush_req     (flush_req),
    .force_release (force_release),
    .stall_err     (stall_err)
  );

  // Flush beats the watchdog, which beats a plain stall.
  always_comb begin
    sel = ADV;
    if (flush_req) begin
      sel = REDIR;
    end else if (stall_req && !force_release) begin
      sel = HOLD;
    end
  end

  always_comb begin
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    if_valid_d = if_valid_q;
    bubble_d   = bubble_q;
    unique case (sel)
      REDIR: begin
        pc_d       = {flush_target[XLEN-1:2], 2'b00};
        if_pc_d    = '0;
        if_inst_d  = XLEN'(NOP_INST);
        if_valid_d = 1'b0;
        bubble_d   = bubble_q + CNT_W'(1);
      end
      HOLD: begin
        bubble_d = bubble_q + CNT_W'(1);
      end
      default: begin
        pc_d       = pc_q + XLEN'(PC_STEP);
        if_pc_d    = pc_q;
        if_inst_d  = imem_rdata;
        if_valid_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      pc_q       <= RESET_PC;
      if_pc_q    <= '0;
      if_inst_q  <= XLEN'(NOP_INST);
      if_valid_q <= 1'b0;
      bubble_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      if_valid_q <= if_valid_d;
      bubble_q   <= bubble_d;
    end
  end

  assign imem_addr  = pc_q;
  assign if_pc      = if_pc_q;
  assign if_inst    = if_inst_q;
  assign if_valid   = if_valid_q;
  assign bubble_cnt = bubble_q;

endmodule
